rcc_div_ratio_det: RTL and testbench
====================================

Name: rcc_div_ratio_det

Overview:
- Monitors the `div_en` marker stream produced by the dynamic 1/2/4/8/16 clock divider.
- Measures the spacing between markers in `i_clk` cycles and decodes it back to the divider's 3-bit select code.
- Sits beside the divider in the RCC block and confirms that the programmed ratio actually took effect.
- Provides a lock indication, a mismatch flag against the expected select, and error/timeout reporting for dead or illegal marker streams.

Parameters:
- LOCK_CNT, 3: number of consecutive identical legal periods required before lock; legal range 1..7.
- TIMEOUT, 32: `i_clk` cycles without a marker before the stream is declared stalled; must be 17..63.

Ports:
- i_clk  input  1  single clock; the same clock that feeds the divider.
- rst  input  1  reset, asynchronous and active-high.
- div_en  input  1  divider marker; high one cycle per divided period (constant high at /1).
- exp_sel  input  3  expected divider select, same encoding as divider `div_sel`.
- det_sel  output  3  decoded select of the measured stream.
- det_vld  output  1  lock indication; `det_sel` is trustworthy while high.
- mismatch  output  1  high while locked and the decoded ratio differs from the `exp_sel` ratio.
- err  output  1  one-cycle pulse on an illegal period or on timeout.
- stalled  output  1  high from timeout until the next marker.

Behaviour:
- Reset: `det_sel` = 000, `det_vld` = 0, `mismatch` = 0, `err` = 0, `stalled` = 0, state = ACQ, gap counter = 0, match count = 0. All outputs are registered.
- Select encoding (shared with the divider):
  - 100 → /2, 101 → /4, 110 → /8, 111 → /16.
  - 000, 001, 010, 011 → /1; the detector always reports 000 for /1.
- Gap counter:
  - 6 bits; reset to 1 on any cycle with `div_en` = 1; otherwise increments, saturating at TIMEOUT.
- Period P: the value of the gap counter in a cycle where `div_en` = 1.
  - P counts cycles since the previous marker, so constant-high `div_en` gives P = 1.
  - Legal P values: 1, 2, 4, 8, 16; all others are illegal.
- State ACQ (after reset or timeout):
  - The first marker measures nothing; it only starts timing. Next state MEAS, match count = 0.
- State MEAS, on each marker:
  - Illegal P: `err` pulses, candidate cleared, match count = 0, stay MEAS.
  - Legal P equal to candidate: match count +1.
  - Legal P different from candidate: candidate = P, match count = 1.
  - Match count reaching LOCK_CNT: state LOCK; `det_sel` = code(candidate) and `det_vld` = 1 on the next cycle.
- State LOCK, on each marker:
  - Equal P: no change.
  - Different legal P: `det_vld` drops next cycle, candidate = P, match count = 1, state MEAS; `det_sel` holds its last locked value.
  - Illegal P: `err` pulse, `det_vld` drops, match count = 0, state MEAS.
- Timeout (any state except ACQ): gap counter reaches TIMEOUT with no marker.
  - `err` pulses once.
  - `stalled` = 1, `det_vld` = 0, state ACQ.
  - `stalled` clears in the cycle after the next marker.
- Mismatch:
  - `mismatch` = `det_vld` AND ratio(`exp_sel`) ≠ ratio(`det_sel`), registered.
  - Updates one cycle after an `exp_sel` change; forced 0 whenever `det_vld` = 0.
- Simultaneous events: a marker in the cycle the counter would reach TIMEOUT counts as a marker; no timeout is raised.
- Lock latency: with markers at cycles 0, T, 2T, …, `det_vld` rises at cycle LOCK_CNT·T + 1.
- Reset mid-operation: returns to reset values immediately (asynchronous); the first marker after release measures nothing.

Decomposition:
- Shared package `rcc_pkg`:
  - select-code constants for /1, /2, /4, /8, /16;
  - function period-to-code;
  - function code-to-ratio (normalises 000..011 to /1);
  - gap counter width constant.
- One sub-module `rcc_gap_cnt`: saturating gap counter that emits P and a timeout strobe. FSM and lock logic stay in the top.

Test Plan:
- Reset, then `div_en` pulsing every 4 cycles from cycle 0, `exp_sel` = 101, LOCK_CNT = 3 → `det_vld` rises at cycle 13, `det_sel` = 101, `mismatch` = 0, `err` never pulses.
- `div_en` held constant high, `exp_sel` = 010 → lock at cycle 4 with `det_sel` = 000 and `mismatch` = 0. Then change `exp_sel` to 110 → `mismatch` = 1 one cycle later.
- Locked at /8, markers switch to every 16 cycles → `det_vld` falls the cycle after the first 16-gap marker. It relocks with `det_sel` = 111 after three 16-gap periods.
- Markers with a gap of 3 inserted while locked at /2 → single-cycle `err`, `det_vld` = 0. Relock at /2 after three further 2-gaps.
- Markers stop while locked (TIMEOUT = 32) → `err` pulses and `stalled` = 1 exactly 32 cycles after the last marker. The next marker clears `stalled`, and lock needs LOCK_CNT fresh periods after that.
- Assert `rst` asynchronously mid-MEAS at /16 → all outputs 0 immediately. After release, the first marker measures nothing and lock comes at 3·16 + 1 cycles after it.

Source files
------------

// File: rtl/rcc_pkg.sv
// Shared definitions for the RCC divider ratio detector: select codes,
// period/code/ratio conversions and detector state encoding.
package rcc_pkg;

  localparam int GAP_W = 6;

  localparam logic [2:0] SEL_D1  = 3'b000;
  localparam logic [2:0] SEL_D2  = 3'b100;
  localparam logic [2:0] SEL_D4  = 3'b101;
  localparam logic [2:0] SEL_D8  = 3'b110;
  localparam logic [2:0] SEL_D16 = 3'b111;

  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_MEAS = 2'd1,
    ST_LOCK = 2'd2
  } det_state_t;

  function automatic logic period_legal(input logic [GAP_W-1:0] p);
    return (p == 6'd1) || (p == 6'd2) || (p == 6'd4) || (p == 6'd8) || (p == 6'd16);
  endfunction

  // Illegal periods map to /1; callers gate with period_legal().
  function automatic logic [2:0] period_to_code(input logic [GAP_W-1:0] p);
    logic [2:0] code;
    case (p)
      6'd2:    code = SEL_D2;
      6'd4:    code = SEL_D4;
      6'd8:    code = SEL_D8;
      6'd16:   code = SEL_D16;
      default: code = SEL_D1;
    endcase
    return code;
  endfunction

  function automatic logic [4:0] code_to_ratio(input logic [2:0] sel);
    logic [4:0] r;
    case (sel)
      SEL_D2:  r = 5'd2;
      SEL_D4:  r = 5'd4;
      SEL_D8:  r = 5'd8;
      SEL_D16: r = 5'd16;
      default: r = 5'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rcc_gap_cnt.sv
// Saturating gap counter: reloads to 1 on every marker, reports the current
// gap as the period P and strobes timeout on the cycle it would hit TIMEOUT.
module rcc_gap_cnt
  import rcc_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_en,
  output logic [GAP_W-1:0] gap,
  output logic             timeout
);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (div_en) begin
      cnt <= GAP_W'(1);
    end else if (cnt != GAP_W'(TIMEOUT)) begin
      cnt <= cnt + GAP_W'(1);
    end
  end

  // A marker in the reaching cycle wins, so the strobe is masked by div_en.
  assign timeout = !div_en && (cnt == GAP_W'(TIMEOUT - 1));
  assign gap     = cnt;

endmodule

// File: rtl/rcc_div_ratio_det.sv
// Divider ratio detector: decodes the div_en marker spacing back to a select
// code, locks after LOCK_CNT identical legal periods, flags mismatch/errors.
module rcc_div_ratio_det
  import rcc_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int TIMEOUT  = 32
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       div_en,
  input  logic [2:0] exp_sel,
  output logic [2:0] det_sel,
  output logic       det_vld,
  output logic       mismatch,
  output logic       err,
  output logic       stalled,
  output det_state_t dbg_state
);

  logic [GAP_W-1:0] gap;
  logic             timeout;

  det_state_t       state, state_nxt;
  logic [GAP_W-1:0] cand, cand_nxt;
  logic [2:0]       mcnt, mcnt_nxt, cnt_new;
  logic [2:0]       sel_nxt;
  logic             vld_nxt, mm_nxt, err_nxt, stalled_nxt;
  logic             p_legal;

  rcc_gap_cnt #(.TIMEOUT(TIMEOUT)) u_gap_cnt (
    .clk     (i_clk),
    .rst     (rst),
    .div_en  (div_en),
    .gap     (gap),
    .timeout (timeout)
  );

  assign p_legal = period_legal(gap);

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      state    <= ST_ACQ;
      cand     <= '0;
      mcnt     <= '0;
      det_sel  <= SEL_D1;
      det_vld  <= 1'b0;
      mismatch <= 1'b0;
      err      <= 1'b0;
      stalled  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cand     <= cand_nxt;
      mcnt     <= mcnt_nxt;
      det_sel  <= sel_nxt;
      det_vld  <= vld_nxt;
      mismatch <= mm_nxt;
      err      <= err_nxt;
      stalled  <= stalled_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    mcnt_nxt    = mcnt;
    cnt_new     = mcnt;
    sel_nxt     = det_sel;
    vld_nxt     = det_vld;
    err_nxt     = 1'b0;
    stalled_nxt = stalled && !div_en;

    case (state)
      ST_ACQ: begin
        // First marker after acquisition only starts timing.
        if (div_en) begin
          state_nxt = ST_MEAS;
          cand_nxt  = '0;
          mcnt_nxt  = '0;
        end
      end
      ST_MEAS: begin
        if (div_en) begin
          if (!p_legal) begin
            err_nxt  = 1'b1;
            cand_nxt = '0;
            mcnt_nxt = '0;
          end else begin
            if (gap == cand) begin
              cnt_new = mcnt + 3'd1;
            end else begin
              cnt_new  = 3'd1;
              cand_nxt = gap;
            end
            mcnt_nxt = cnt_new;
            if (cnt_new >= 3'(LOCK_CNT)) begin
              state_nxt = ST_LOCK;
              vld_nxt   = 1'b1;
              sel_nxt   = period_to_code(gap);
            end
          end
        end
      end
      ST_LOCK: begin
        // det_sel keeps the last locked value when lock is lost.
        if (div_en && (!p_legal || gap != cand)) begin
          state_nxt = ST_MEAS;
          vld_nxt   = 1'b0;
          if (!p_legal) begin
            err_nxt  = 1'b1;
            cand_nxt = '0;
            mcnt_nxt = '0;
          end else begin
            cand_nxt = gap;
            mcnt_nxt = 3'd1;
          end
        end
      end
      default: state_nxt = ST_ACQ;
    endcase

    if (timeout && state != ST_ACQ) begin
      state_nxt   = ST_ACQ;
      err_nxt     = 1'b1;
      stalled_nxt = 1'b1;
      vld_nxt     = 1'b0;
      cand_nxt    = '0;
      mcnt_nxt    = '0;
    end

    // Built from next-state values so mismatch tracks det_vld exactly.
    mm_nxt = vld_nxt && (code_to_ratio(exp_sel) != code_to_ratio(sel_nxt));
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rcc_div_ratio_det.sv
// Directed bench for rcc_div_ratio_det: per-ratio lock table plus sequences
// for ratio change, illegal gaps, timeout and asynchronous reset.
module tb_rcc_div_ratio_det;
  import rcc_pkg::*;

  logic       clk;
  logic       rst;
  logic       div_en;
  logic [2:0] exp_sel;
  logic [2:0] det_sel;
  logic       det_vld;
  logic       mismatch;
  logic       err;
  logic       stalled;
  det_state_t dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;

  typedef struct {
    int         per;
    logic [2:0] es;
    logic [2:0] sel;
    logic       mm;
  } vec_t;

  vec_t vecs[6];
  logic [2:0] exp_q[$];

  rcc_div_ratio_det #(.LOCK_CNT(3), .TIMEOUT(32)) dut (
    .i_clk     (clk),
    .rst       (rst),
    .div_en    (div_en),
    .exp_sel   (exp_sel),
    .det_sel   (det_sel),
    .det_vld   (det_vld),
    .mismatch  (mismatch),
    .err       (err),
    .stalled   (stalled),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic de);
    div_en = de;
    @(posedge clk);
    #1;
    err_cnt += int'(err);
  endtask

  task automatic marker_after(input int gap);
    for (int i = 1; i < gap; i++) step(1'b0);
    step(1'b1);
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    div_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst     = 1'b0;
    err_cnt = 0;
  endtask

  initial begin
    rst     = 1'b1;
    div_en  = 1'b0;
    exp_sel = 3'b000;

    vecs[0] = '{per: 4,  es: 3'b101, sel: 3'b101, mm: 1'b0};
    vecs[1] = '{per: 1,  es: 3'b010, sel: 3'b000, mm: 1'b0};
    vecs[2] = '{per: 2,  es: 3'b100, sel: 3'b100, mm: 1'b0};
    vecs[3] = '{per: 8,  es: 3'b111, sel: 3'b110, mm: 1'b1};
    vecs[4] = '{per: 16, es: 3'b111, sel: 3'b111, mm: 1'b0};
    vecs[5] = '{per: 1,  es: 3'b101, sel: 3'b000, mm: 1'b1};

    // Reset values.
    do_reset();
    check("rst_det_sel", int'(det_sel), 0);
    check("rst_det_vld", int'(det_vld), 0);
    check("rst_mismatch", int'(mismatch), 0);
    check("rst_err", int'(err), 0);
    check("rst_stalled", int'(stalled), 0);
    check("rst_state", int'(dbg_state), int'(ST_ACQ));

    // Lock per ratio: markers at 0, T, 2T, 3T; det_vld must rise at 3T+1.
    foreach (vecs[i]) exp_q.push_back(vecs[i].sel);
    for (int i = 0; i < 6; i++) begin
      logic [2:0] want_sel;
      do_reset();
      exp_sel = vecs[i].es;
      want_sel = exp_q.pop_front();
      step(1'b1);
      marker_after(vecs[i].per);
      marker_after(vecs[i].per);
      for (int k = 1; k < vecs[i].per; k++) step(1'b0);
      check($sformatf("tbl%0d_vld_early", i), int'(det_vld), 0);
      step(1'b1);
      check($sformatf("tbl%0d_vld", i), int'(det_vld), 1);
      check($sformatf("tbl%0d_sel", i), int'(det_sel), int'(want_sel));
      check($sformatf("tbl%0d_mm", i), int'(mismatch), int'(vecs[i].mm));
      check($sformatf("tbl%0d_noerr", i), err_cnt, 0);
    end

    // Constant high at /1, then exp_sel changes: mismatch one cycle later.
    do_reset();
    exp_sel = 3'b010;
    repeat (4) step(1'b1);
    check("c1_vld", int'(det_vld), 1);
    check("c1_mm0", int'(mismatch), 0);
    exp_sel = 3'b110;
    step(1'b1);
    check("c1_mm1", int'(mismatch), 1);
    exp_sel = 3'b011;
    step(1'b1);
    check("c1_mm_norm", int'(mismatch), 0);

    // Locked at /8, stream switches to /16.
    do_reset();
    exp_sel = 3'b110;
    step(1'b1);
    repeat (3) marker_after(8);
    check("r8_vld", int'(det_vld), 1);
    check("r8_sel", int'(det_sel), 6);
    marker_after(16);
    check("r16_drop", int'(det_vld), 0);
    check("r16_hold_sel", int'(det_sel), 6);
    marker_after(16);
    check("r16_vld_early", int'(det_vld), 0);
    marker_after(16);
    check("r16_vld", int'(det_vld), 1);
    check("r16_sel", int'(det_sel), 7);
    check("r16_mm", int'(mismatch), 1);

    // Locked at /2, an illegal gap of 3 then relock.
    do_reset();
    exp_sel = 3'b100;
    step(1'b1);
    repeat (3) marker_after(2);
    check("r2_vld", int'(det_vld), 1);
    marker_after(3);
    check("g3_err", int'(err), 1);
    check("g3_vld", int'(det_vld), 0);
    step(1'b0);
    check("g3_err_single", int'(err), 0);
    step(1'b1);
    marker_after(2);
    check("g3_vld_early", int'(det_vld), 0);
    marker_after(2);
    check("g3_relock", int'(det_vld), 1);
    check("g3_sel", int'(det_sel), 4);

    // Marker exactly in the cycle the counter reaches 31: illegal, not a timeout.
    marker_after(31);
    check("g31_err", int'(err), 1);
    check("g31_stalled", int'(stalled), 0);
    check("g31_vld", int'(det_vld), 0);
    repeat (3) marker_after(2);
    check("g31_relock", int'(det_vld), 1);

    // Markers stop: err/stalled exactly 32 cycles after the last marker.
    err_cnt = 0;
    repeat (30) step(1'b0);
    check("to_err_early", int'(err), 0);
    check("to_stalled_early", int'(stalled), 0);
    check("to_vld_early", int'(det_vld), 1);
    step(1'b0);
    check("to_err", int'(err), 1);
    check("to_stalled", int'(stalled), 1);
    check("to_vld", int'(det_vld), 0);
    check("to_state", int'(dbg_state), int'(ST_ACQ));
    step(1'b0);
    check("to_err_single", int'(err), 0);
    repeat (10) step(1'b0);
    check("to_stalled_hold", int'(stalled), 1);
    check("to_err_once", err_cnt, 1);
    step(1'b1);
    check("to_stalled_clr", int'(stalled), 0);
    marker_after(2);
    marker_after(2);
    check("to_vld_early2", int'(det_vld), 0);
    marker_after(2);
    check("to_relock", int'(det_vld), 1);

    // Asynchronous reset mid-MEAS with a held det_sel, then fresh lock at /16.
    do_reset();
    exp_sel = 3'b111;
    step(1'b1);
    repeat (3) marker_after(8);
    check("ar_mm_locked", int'(mismatch), 1);
    marker_after(16);
    check("ar_meas_sel", int'(det_sel), 6);
    repeat (3) step(1'b0);
    #2 rst = 1'b1;
    #1;
    check("ar_det_sel", int'(det_sel), 0);
    check("ar_det_vld", int'(det_vld), 0);
    check("ar_mismatch", int'(mismatch), 0);
    check("ar_stalled", int'(stalled), 0);
    check("ar_state", int'(dbg_state), int'(ST_ACQ));
    @(negedge clk);
    rst = 1'b0;
    step(1'b1);
    marker_after(16);
    marker_after(16);
    for (int k = 1; k < 16; k++) step(1'b0);
    check("ar_vld_early", int'(det_vld), 0);
    step(1'b1);
    check("ar_relock", int'(det_vld), 1);
    check("ar_sel", int'(det_sel), 7);
    check("ar_mm", int'(mismatch), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
